// File: rtl/pkg_ili9341.sv
// Shared constants for the ILI9341-side SPI responder.
package pkg_ili9341;

  localparam int unsigned SPI_WORD_W = 8;

  // FSM encoding
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // dcx meaning
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned SYNC    = 2,     // synchronizer depth, minimum 2
  parameter logic        RST_VAL = 1'b0   // idle level of the pin
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [SYNC-1:0] r_sync;
  logic            r_hist;

  // Shift the pin through the synchronizer and keep one cycle of history for edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {SYNC{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], i_d};
      r_hist <= r_sync[SYNC-1];
    end
  end

  assign o_q      = r_sync[SYNC-1];
  assign o_rise_c = r_sync[SYNC-1] & ~r_hist;
  assign o_fall_c = ~r_sync[SYNC-1] & r_hist;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder sampled entirely in the clk domain: receives words on mosi, returns tx_data on miso.
module spi_slave_rx
  import pkg_ili9341::*;
#(
  parameter int unsigned DW    = SPI_WORD_W,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             csx,
  input  logic             mosi,
  input  logic             dcx,
  output logic             miso,
  output logic [DW-1:0]    rx_data,
  output logic             rx_dc,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  input  logic             ovr_clr,
  output logic             frame_err,
  input  logic [DW-1:0]    tx_data,
  output logic             tx_taken,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy
);

  localparam int unsigned    BCW      = $clog2(DW);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DW - 1);

  logic w_sck_rise, w_sck_fall, w_csx_rise, w_csx_fall, w_mosi, w_dcx;
  logic w_sck_lvl_unused, w_csx_lvl_unused;
  logic w_mosi_rise_unused, w_mosi_fall_unused, w_dcx_rise_unused, w_dcx_fall_unused;

  spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .i_d(sck),
    .o_q(w_sck_lvl_unused), .o_rise_c(w_sck_rise), .o_fall_c(w_sck_fall));

  spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_csx (
    .clk(clk), .rst(rst), .i_d(csx),
    .o_q(w_csx_lvl_unused), .o_rise_c(w_csx_rise), .o_fall_c(w_csx_fall));

  spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(mosi),
    .o_q(w_mosi), .o_rise_c(w_mosi_rise_unused), .o_fall_c(w_mosi_fall_unused));

  spi_sync_edge #(.SYNC(SYNC), .RST_VAL(DC_CMD)) u_sync_dcx (
    .clk(clk), .rst(rst), .i_d(dcx),
    .o_q(w_dcx), .o_rise_c(w_dcx_rise_unused), .o_fall_c(w_dcx_fall_unused));

  logic [0:0]       r_state,     w_state_nxt;
  logic [BCW-1:0]   r_bit_cnt,   w_bit_nxt;
  logic [CNT_W-1:0] r_byte_cnt,  w_byte_nxt;
  logic [DW-2:0]    r_rx_sr,     w_rx_sr_nxt;
  logic [DW-1:0]    r_tx_sr,     w_tx_sr_nxt;
  logic             r_skip_fall, w_skip_nxt;
  logic [DW-1:0]    r_rx_data,   w_rx_data_nxt;
  logic             r_rx_dc,     w_rx_dc_nxt;
  logic             r_rx_valid,  w_rx_valid_nxt;
  logic             r_overrun,   w_overrun_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_tx_taken,  w_tx_taken_nxt;
  logic             r_miso,      w_miso_nxt;
  logic             r_busy,      w_busy_nxt;
  logic [DW-1:0]    w_word;

  assign w_word = {r_rx_sr, w_mosi};

  // Next-state and next-output logic; a sck edge is handled before a coincident csx rise
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_nxt       = r_bit_cnt;
    w_byte_nxt      = r_byte_cnt;
    w_rx_sr_nxt     = r_rx_sr;
    w_tx_sr_nxt     = r_tx_sr;
    w_skip_nxt      = r_skip_fall;
    w_rx_data_nxt   = r_rx_data;
    w_rx_dc_nxt     = r_rx_dc;
    w_rx_valid_nxt  = r_rx_valid & ~rx_ready;
    w_overrun_nxt   = r_overrun & ~ovr_clr;
    w_frame_err_nxt = 1'b0;
    w_tx_taken_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_csx_fall) begin
          w_state_nxt    = S_SHIFT;
          w_bit_nxt      = '0;
          w_byte_nxt     = '0;
          w_tx_sr_nxt    = tx_data;
          w_tx_taken_nxt = 1'b1;
          w_skip_nxt     = 1'b0;
        end
      end
      S_SHIFT: begin
        if (w_sck_rise) begin
          w_rx_sr_nxt = w_word[DW-2:0];
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nxt      = '0;
            w_tx_sr_nxt    = tx_data;
            w_tx_taken_nxt = 1'b1;
            w_skip_nxt     = 1'b1;
            if (r_byte_cnt != '1) begin
              w_byte_nxt = r_byte_cnt + CNT_W'(1);
            end
            if (!r_rx_valid || rx_ready) begin
              w_rx_data_nxt  = w_word;
              w_rx_dc_nxt    = w_dcx;
              w_rx_valid_nxt = 1'b1;
            end else begin
              w_overrun_nxt = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + BCW'(1);
          end
        end else if (w_sck_fall) begin
          // the fall right after a boundary reload must keep the new MSB on miso
          if (r_skip_fall) begin
            w_skip_nxt = 1'b0;
          end else begin
            w_tx_sr_nxt = {r_tx_sr[DW-2:0], 1'b1};
          end
        end
        if (w_csx_rise) begin
          w_state_nxt     = S_IDLE;
          w_frame_err_nxt = (w_bit_nxt != '0);
          w_bit_nxt       = '0;
          w_rx_sr_nxt     = '1;
          w_skip_nxt      = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == S_SHIFT);
    w_miso_nxt = w_busy_nxt ? w_tx_sr_nxt[DW-1] : 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_rx_sr     <= '1;
      r_tx_sr     <= '1;
      r_skip_fall <= 1'b0;
      r_rx_data   <= '0;
      r_rx_dc     <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_taken  <= 1'b0;
      r_miso      <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_byte_cnt  <= w_byte_nxt;
      r_rx_sr     <= w_rx_sr_nxt;
      r_tx_sr     <= w_tx_sr_nxt;
      r_skip_fall <= w_skip_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_dc     <= w_rx_dc_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_overrun   <= w_overrun_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_tx_taken  <= w_tx_taken_nxt;
      r_miso      <= w_miso_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign miso       = r_miso;
  assign rx_data    = r_rx_data;
  assign rx_dc      = r_rx_dc;
  assign rx_valid   = r_rx_valid;
  assign rx_overrun = r_overrun;
  assign frame_err  = r_frame_err;
  assign tx_taken   = r_tx_taken;
  assign byte_cnt   = r_byte_cnt;
  assign busy       = r_busy;

endmodule
